mem_wb_stage: RTL and testbench

- Memory stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes its MEM_* outputs and runs the data-memory req/ack handshake, with a timeout.
- Resolves branches from the registered flags and raises a stall to the hazard logic while an access is outstanding.
- Holds the MEM/WB pipeline register that feeds register-file writeback.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/branch_resolve.sv | 39 +++
 rtl/mem_wb_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the memory/writeback stage: branch
//               condition codes, memory-access FSM states, timeout default.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Branch condition codes carried on MEM_branch_cond
  localparam logic [2:0] BR_NONE   = 3'b000;  // never
  localparam logic [2:0] BR_Z      = 3'b001;  // zero
  localparam logic [2:0] BR_NZ     = 3'b010;  // not zero
  localparam logic [2:0] BR_N      = 3'b011;  // negative
  localparam logic [2:0] BR_GT     = 3'b100;  // not negative and not zero
  localparam logic [2:0] BR_LE     = 3'b101;  // negative or zero
  localparam logic [2:0] BR_OV     = 3'b110;  // overflow
  localparam logic [2:0] BR_ALWAYS = 3'b111;  // unconditional

  // Data-memory access sequencer states
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_WAIT = 2'b01,
    MS_DONE = 2'b10
  } mem_state_t;

  // Default number of WAIT cycles before an access is abandoned
  localparam int TIMEOUT_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational branch decision from a condition code and the
//               ALU flags, qualified by an enable.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_ov,
  input  logic       flag_neg,
  input  logic       flag_zero,
  input  logic       enable,
  output logic       taken
);

  logic hit;

  // Evaluate the condition code against the flags, then gate with enable
  always_comb begin
    hit = 1'b0;
    case (cond)
      BR_NONE:   hit = 1'b0;
      BR_Z:      hit = flag_zero;
      BR_NZ:     hit = ~flag_zero;
      BR_N:      hit = flag_neg;
      BR_GT:     hit = ~flag_neg & ~flag_zero;
      BR_LE:     hit = flag_neg | flag_zero;
      BR_OV:     hit = flag_ov;
      BR_ALWAYS: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    taken = enable & hit;
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory stage: runs the data-memory req/ack handshake with a
//               timeout, stalls upstream while an access is outstanding,
//               resolves branches and holds the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              MEM_re,
  input  logic              MEM_we,
  input  logic              MEM_mem_ALU_select,
  input  logic              MEM_sprite_ALU_select,
  input  logic              MEM_use_dst_reg,
  input  logic              MEM_flag_ov,
  input  logic              MEM_flag_neg,
  input  logic              MEM_flag_zero,
  input  logic [2:0]        MEM_branch_cond,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [31:0]       MEM_data,
  input  logic [31:0]       MEM_ALU_result,
  input  logic [31:0]       MEM_sprite_data,
  input  logic [21:0]       MEM_PC_out,
  input  logic [4:0]        MEM_dst_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              branch_taken,
  output logic [21:0]       branch_target,
  output logic              WB_use_dst_reg,
  output logic [4:0]        WB_dst_reg,
  output logic [31:0]       WB_data
);

  // Last counter value of the WAIT window; the counter starts at 0 on entry
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state;
  mem_state_t  state_nxt;
  logic        access;
  logic        start;
  logic        got_ack;
  logic        timed_out;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic [31:0] wb_data_nxt;
  logic        wb_suppress;
  logic        br_enable;

  // A store wins when both request bits are set (dmem_we follows MEM_we)
  assign access = MEM_re | MEM_we;

  // Access sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, handshake events and upstream stall
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    got_ack   = 1'b0;
    timed_out = 1'b0;
    mem_stall = 1'b0;
    case (state)
      MS_IDLE: begin
        mem_stall = access;
        if (access && !hlt) begin
          start     = 1'b1;
          state_nxt = MS_WAIT;
        end
      end
      MS_WAIT: begin
        // hlt deliberately does not abort an outstanding access
        mem_stall = 1'b1;
        if (dmem_ack) begin
          got_ack   = 1'b1;
          state_nxt = MS_DONE;
        end else if (cnt == CNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = MS_DONE;
        end
      end
      MS_DONE: begin
        // Stall released here so upstream advances at the end of DONE
        state_nxt = MS_IDLE;
      end
      default: begin
        state_nxt = MS_IDLE;
      end
    endcase
  end

  // Memory interface registers, wait counter, read-data capture, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MEM_we;
        dmem_addr  <= MEM_addr;
        dmem_wdata <= MEM_data;
        cnt        <= '0;
      end else if (got_ack) begin
        dmem_req <= 1'b0;
        rdata_q  <= dmem_rdata;
      end else if (timed_out) begin
        dmem_req <= 1'b0;
        rdata_q  <= '0;
        mem_err  <= 1'b1;
      end else if (state == MS_WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Writeback source select; in DONE the captured read data is used
  assign wb_data_nxt = MEM_mem_ALU_select
                     ? ((state == MS_DONE) ? rdata_q : dmem_rdata)
                     : (MEM_sprite_ALU_select ? MEM_sprite_data : MEM_ALU_result);

  // A store completing in DONE must not write the register file
  assign wb_suppress = (state == MS_DONE) & MEM_we;

  // MEM/WB pipeline register: frozen by hlt, bubble while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_use_dst_reg <= 1'b0;
      WB_dst_reg     <= '0;
      WB_data        <= '0;
    end else if (!hlt) begin
      if (mem_stall) begin
        WB_use_dst_reg <= 1'b0;
      end else begin
        WB_use_dst_reg <= MEM_use_dst_reg & ~wb_suppress;
        WB_dst_reg     <= MEM_dst_reg;
        WB_data        <= wb_data_nxt;
      end
    end
  end

  assign br_enable     = ~hlt & ~mem_stall;
  assign branch_target = MEM_PC_out;

  branch_resolve u_branch_resolve (
    .cond      (MEM_branch_cond),
    .flag_ov   (MEM_flag_ov),
    .flag_neg  (MEM_flag_neg),
    .flag_zero (MEM_flag_zero),
    .enable    (br_enable),
    .taken     (branch_taken)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Expected writebacks are
//               queued by the stimulus; a monitor pops them on every WB update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hlt;
  logic        MEM_re, MEM_we, MEM_mem_ALU_select, MEM_sprite_ALU_select;
  logic        MEM_use_dst_reg, MEM_flag_ov, MEM_flag_neg, MEM_flag_zero;
  logic [2:0]  MEM_branch_cond;
  logic [4:0]  MEM_addr;
  logic [31:0] MEM_data, MEM_ALU_result, MEM_sprite_data;
  logic [21:0] MEM_PC_out;
  logic [4:0]  MEM_dst_reg;
  logic        dmem_req, dmem_we;
  logic [4:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, mem_err, branch_taken;
  logic [21:0] branch_target;
  logic        WB_use_dst_reg;
  logic [4:0]  WB_dst_reg;
  logic [31:0] WB_data;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered while an instruction is held in the stage
  int          req_cycles, stall_cycles, err_count;
  logic        seen_we;
  logic [4:0]  seen_addr;
  logic [31:0] seen_wdata;
  logic        bt_during_stall;

  mem_wb_stage #(.ADDR_W(5), .TIMEOUT(16)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hlt                   (hlt),
    .MEM_re                (MEM_re),
    .MEM_we                (MEM_we),
    .MEM_mem_ALU_select    (MEM_mem_ALU_select),
    .MEM_sprite_ALU_select (MEM_sprite_ALU_select),
    .MEM_use_dst_reg       (MEM_use_dst_reg),
    .MEM_flag_ov           (MEM_flag_ov),
    .MEM_flag_neg          (MEM_flag_neg),
    .MEM_flag_zero         (MEM_flag_zero),
    .MEM_branch_cond       (MEM_branch_cond),
    .MEM_addr              (MEM_addr),
    .MEM_data              (MEM_data),
    .MEM_ALU_result        (MEM_ALU_result),
    .MEM_sprite_data       (MEM_sprite_data),
    .MEM_PC_out            (MEM_PC_out),
    .MEM_dst_reg           (MEM_dst_reg),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .mem_stall             (mem_stall),
    .mem_err               (mem_err),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target),
    .WB_use_dst_reg        (WB_use_dst_reg),
    .WB_dst_reg            (WB_dst_reg),
    .WB_data               (WB_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every unfrozen WB update that enables writeback consumes one expectation
  logic mon_hlt, mon_rst;
  always @(posedge clk) begin
    mon_hlt = hlt;
    mon_rst = rst_n;
    #1;
    if (mon_rst && rst_n && !mon_hlt && WB_use_dst_reg) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got dst %0d data 0x%08h expected no writeback",
                 WB_dst_reg, WB_data);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check("wb_dst", 32'(WB_dst_reg), 32'(e.dst));
        check("wb_data", WB_data, e.data);
      end
    end
  end

  task automatic set_instr(input logic re, input logic we, input logic msel,
                           input logic ssel, input logic use_dst, input logic [4:0] dst,
                           input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [31:0] alu, input logic [31:0] sprite);
    MEM_re = re; MEM_we = we; MEM_mem_ALU_select = msel; MEM_sprite_ALU_select = ssel;
    MEM_use_dst_reg = use_dst; MEM_dst_reg = dst; MEM_addr = addr; MEM_data = wdata;
    MEM_ALU_result = alu; MEM_sprite_data = sprite;
  endtask

  // Hold the current instruction until it retires (called just after a negedge);
  // acknowledges on the ack_at-th cycle dmem_req is seen high (0 = never)
  task automatic run_instr(input int ack_at, input logic [31:0] rdata);
    logic s;
    int   guard;
    req_cycles = 0; stall_cycles = 0; err_count = 0; guard = 0;
    bt_during_stall = 1'b0;
    do begin
      #1;
      if (dmem_req) begin
        req_cycles++;
        seen_we = dmem_we; seen_addr = dmem_addr; seen_wdata = dmem_wdata;
        if (req_cycles == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
      end
      if (mem_err) err_count++;
      if (branch_taken && mem_stall) bt_during_stall = 1'b1;
      s = mem_stall | hlt;
      if (s) stall_cycles++;
      @(negedge clk);
      guard++;
    end while (s && guard < 200);
    dmem_ack = 1'b0;
    if (s) begin
      n_checks++;
      n_fail++;
      $display("FAIL retire_timeout: got still stalled after %0d cycles expected retire", guard);
    end
  endtask

  typedef struct {
    logic [2:0] cond;
    logic       ov, n, z, h;
    logic       exp;
  } br_vec_t;

  br_vec_t br_tab[11] = '{
    '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
    '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
    '{3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    rst_n = 1'b0; hlt = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    MEM_flag_ov = 1'b0; MEM_flag_neg = 1'b0; MEM_flag_zero = 1'b0;
    MEM_branch_cond = 3'b000; MEM_PC_out = 22'h0;
    set_instr(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_use", 32'(WB_use_dst_reg), 32'd0);
    check("rst_wb_data", WB_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load, ack in first WAIT cycle
    set_instr(1, 0, 1, 0, 1, 5'd7, 5'd5, 32'h0, 32'h0, 32'h0);
    exp_q.push_back('{5'd7, 32'h1234_5678});
    run_instr(1, 32'h1234_5678);
    check("ld_stall_cycles", 32'(stall_cycles), 32'd2);
    check("ld_req_cycles", 32'(req_cycles), 32'd1);
    check("ld_addr", 32'(seen_addr), 32'd5);
    check("ld_we", 32'(seen_we), 32'd0);
    set_instr(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check("ld_wb_use", 32'(WB_use_dst_reg), 32'd1);
    check("ld_wb_dst", 32'(WB_dst_reg), 32'd7);
    check("ld_wb_data", WB_data, 32'h1234_5678);
    run_instr(0, 32'h0);
    #1;
    check("ld_wb_one_cycle", 32'(WB_use_dst_reg), 32'd0);

    // Store to addr 31, ack after 4 WAIT cycles; writeback must be suppressed
    set_instr(0, 1, 0, 0, 1, 5'd9, 5'd31, 32'hCAFE_0001, 32'h0, 32'h0);
    run_instr(4, 32'h0);
    check("st_req_cycles", 32'(req_cycles), 32'd4);
    check("st_stall_cycles", 32'(stall_cycles), 32'd5);
    check("st_we", 32'(seen_we), 32'd1);
    check("st_addr", 32'(seen_addr), 32'd31);
    check("st_wdata", seen_wdata, 32'hCAFE_0001);
    check("st_err", 32'(err_count), 32'd0);
    #1;
    check("st_no_wb", 32'(WB_use_dst_reg), 32'd0);

    // re and we together behave as a store
    set_instr(1, 1, 1, 0, 1, 5'd10, 5'd12, 32'h0000_BEEF, 32'h0, 32'h0);
    run_instr(1, 32'h5555_5555);
    check("rw_we", 32'(seen_we), 32'd1);
    check("rw_wdata", seen_wdata, 32'h0000_BEEF);

    // Load with no ack: 16 WAIT cycles, one error pulse, data 0; branch held off
    MEM_branch_cond = 3'b111;
    set_instr(1, 0, 1, 0, 1, 5'd3, 5'd2, 32'h0, 32'h0, 32'h0);
    exp_q.push_back('{5'd3, 32'h0});
    run_instr(0, 32'h0);
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_stall_cycles", 32'(stall_cycles), 32'd17);
    check("to_err_pulses", 32'(err_count), 32'd1);
    check("to_branch_in_stall", 32'(bt_during_stall), 32'd0);
    set_instr(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check("to_wb_data", WB_data, 32'h0);
    check("to_mem_err_cleared", 32'(mem_err), 32'd0);

    // Branch condition table
    MEM_PC_out = 22'h2A_5A5A;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      MEM_branch_cond = br_tab[i].cond;
      MEM_flag_ov = br_tab[i].ov; MEM_flag_neg = br_tab[i].n; MEM_flag_zero = br_tab[i].z;
      hlt = br_tab[i].h;
      #1;
      check($sformatf("br_taken_%0d", i), 32'(branch_taken), 32'(br_tab[i].exp));
    end
    check("br_target", 32'(branch_target), 32'h2A_5A5A);
    MEM_branch_cond = 3'b000; hlt = 1'b0;
    @(negedge clk);

    // ALU write, then sprite select held off by hlt
    set_instr(0, 0, 0, 0, 1, 5'd2, 5'd0, 32'h0, 32'h0000_0055, 32'h0);
    exp_q.push_back('{5'd2, 32'h0000_0055});
    run_instr(0, 32'h0);
    set_instr(0, 0, 0, 1, 1, 5'd4, 5'd0, 32'h0, 32'h0000_0011, 32'h0000_00AA);
    exp_q.push_back('{5'd4, 32'h0000_00AA});
    hlt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("hlt_hold_data", WB_data, 32'h0000_0055);
      check("hlt_hold_dst", 32'(WB_dst_reg), 32'd2);
    end
    hlt = 1'b0;
    run_instr(0, 32'h0);
    #1;
    check("sprite_wb_data", WB_data, 32'h0000_00AA);
    check("sprite_wb_dst", 32'(WB_dst_reg), 32'd4);

    // Reset in WAIT cycle 2, then a stray ack must not write back
    set_instr(1, 0, 1, 0, 1, 5'd12, 5'd6, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rstmid_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    set_instr(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check("rstmid_req", 32'(dmem_req), 32'd0);
    check("rstmid_stall", 32'(mem_stall), 32'd0);
    check("rstmid_we", 32'(dmem_we), 32'd0);
    check("rstmid_addr", 32'(dmem_addr), 32'd0);
    check("rstmid_wb_data", WB_data, 32'd0);
    check("rstmid_wb_dst", 32'(WB_dst_reg), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_0077;
    @(negedge clk);
    #1;
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_wb_use", 32'(WB_use_dst_reg), 32'd0);
    check("late_ack_stall", 32'(mem_stall), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
